// File: rtl/fifo_write_arbiter_pkg.sv
// Shared definitions for the FIFO and its write-side arbiter, so that widths and
// state encodings agree between the two.
package fifo_write_arbiter_pkg;

   localparam int BITS_DEF = 8;
   localparam int SIZE_DEF = 16;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Requester bundle plus the FIFO write port.
// The master side drives requests and the full flag; the arbiter is the slave.
interface fifo_write_arbiter_if
   import fifo_write_arbiter_pkg::*;
#(
   parameter int N    = 4,
   parameter int BITS = BITS_DEF
);

   logic [N-1:0]      REQ;
   logic [N*BITS-1:0] DATA;
   logic [N-1:0]      ACK;
   logic [N-1:0]      GRANT;
   logic              FIFO_WE;
   logic [BITS-1:0]   FIFO_DATA;
   logic              FIFO_FULL;
   logic              BUSY;

   modport master (
      output REQ, DATA, FIFO_FULL,
      input  ACK, GRANT, FIFO_WE, FIFO_DATA, BUSY
   );

   modport slave (
      input  REQ, DATA, FIFO_FULL,
      output ACK, GRANT, FIFO_WE, FIFO_DATA, BUSY
   );

endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request at or above ptr, modulo N.
// Shared with the read-side scheduler.
module fifo_write_arbiter_rr_pick #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [PW-1:0] winner,
   output logic          any_valid
);

   logic [PW-1:0] idx;

   // Scan from farthest to nearest, so the nearest match wins the last assignment.
   always_comb begin
      winner    = '0;
      any_valid = 1'b0;
      idx       = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = PW'((int'(ptr) + k) % N);
         if (req[idx]) begin
            winner    = idx;
            any_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among N requesters. A grant covers
// bursts of up to BURST accepted words, with one idle cycle between grants.
module fifo_write_arbiter
   import fifo_write_arbiter_pkg::*;
#(
   parameter int N     = 4,
   parameter int BITS  = BITS_DEF,
   parameter int BURST = 4
) (
   input logic                  CLK,
   input logic                  RESET,
   fifo_write_arbiter_if.slave  bus
);

   localparam int PW = (clog2(N) < 1) ? 1 : clog2(N);
   localparam int CW = (clog2(BURST + 1) < 1) ? 1 : clog2(BURST + 1);
   localparam logic [N-1:0]  ONE      = N'(1);
   localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);

   state_t        state_q, state_d;
   logic [N-1:0]  grant_q, grant_d;
   logic [PW-1:0] gidx_q, gidx_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] winner;
   logic          any_req;
   logic          req_g;
   logic          acc;
   logic [BITS-1:0] fifo_data;

   fifo_write_arbiter_rr_pick #(.N(N), .PW(PW)) u_pick (
      .req       (bus.REQ),
      .ptr       (ptr_q),
      .winner    (winner),
      .any_valid (any_req)
   );

   // Write path is combinational off the grant registers: no added latency, and
   // FULL gates WE directly rather than relying on the FIFO to ignore it.
   assign req_g = bus.REQ[gidx_q];
   assign acc   = (|grant_q) & req_g & ~bus.FIFO_FULL;

   always_comb begin
      fifo_data = '0;
      for (int i = 0; i < N; i++) begin
         if (gidx_q == PW'(i)) fifo_data = bus.DATA[i*BITS +: BITS];
      end
   end

   assign bus.FIFO_WE   = acc;
   assign bus.ACK       = grant_q & {N{acc}};
   assign bus.FIFO_DATA = fifo_data;
   assign bus.GRANT     = grant_q;
   assign bus.BUSY      = (state_q == LOCK);

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gidx_d  = gidx_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d = LOCK;
               grant_d = ONE << winner;
               gidx_d  = winner;
               cnt_d   = '0;
               ptr_d   = (winner == LAST_IDX) ? '0 : winner + PW'(1);
            end
         end
         LOCK: begin
            // A stalled cycle (FULL with request held) leaves everything unchanged.
            if (!req_g || (acc && cnt_q == CNT_LAST)) begin
               state_d = IDLE;
               grant_d = '0;
               gidx_d  = '0;
               cnt_d   = '0;
            end else if (acc) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            gidx_d  = '0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: a BURST=4 instance and a BURST=1 instance,
// with written words checked against a queue of expected (requester, data) entries.
module tb_fifo_write_arbiter;

   localparam int N    = 4;
   localparam int BITS = 8;

   typedef struct {
      int              r;
      logic [BITS-1:0] d;
   } exp_t;

   logic CLK   = 1'b0;
   logic RESET = 1'b1;
   int   errors = 0;
   int   checks = 0;

   exp_t q0[$];
   exp_t q1[$];
   logic [5:0] wc0 [N] = '{default: '0};
   logic [5:0] wc1 [N] = '{default: '0};
   int         ek0 [N] = '{default: 0};
   int         ek1 [N] = '{default: 0};

   fifo_write_arbiter_if #(.N(N), .BITS(BITS)) bus ();
   fifo_write_arbiter_if #(.N(N), .BITS(BITS)) bus1 ();

   fifo_write_arbiter #(.N(N), .BITS(BITS), .BURST(4)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   fifo_write_arbiter #(.N(N), .BITS(BITS), .BURST(1)) dut1 (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus1)
   );

   always #5 CLK = ~CLK;

   // Each requester presents {index, running word number}; the number advances on ACK.
   for (genvar i = 0; i < N; i++) begin : g_data
      assign bus.DATA[i*BITS +: BITS]  = {2'(i), wc0[i]};
      assign bus1.DATA[i*BITS +: BITS] = {2'(i), wc1[i]};
   end

   always @(posedge CLK) begin
      for (int i = 0; i < N; i++) begin
         if (bus.ACK[i])  wc0[i] <= wc0[i] + 6'd1;
         if (bus1.ACK[i]) wc1[i] <= wc1[i] + 6'd1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push0(input int r, input int n);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         e.r = r;
         e.d = {2'(r), 6'(ek0[r])};
         ek0[r]++;
         q0.push_back(e);
      end
   endtask

   task automatic push1(input int r);
      exp_t e;
      e.r = r;
      e.d = {2'(r), 6'(ek1[r])};
      ek1[r]++;
      q1.push_back(e);
   endtask

   always @(negedge CLK) begin : mon0
      exp_t e;
      if (bus.FIFO_WE === 1'b1) begin
         chk("wr0_pending", 32'(q0.size() > 0), 32'd1);
         if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("wr0_data", 32'(bus.FIFO_DATA), 32'(e.d));
            chk("wr0_ack", 32'(bus.ACK), 32'(1 << e.r));
         end
      end
   end

   always @(negedge CLK) begin : mon1
      exp_t e;
      if (bus1.FIFO_WE === 1'b1) begin
         chk("wr1_pending", 32'(q1.size() > 0), 32'd1);
         if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("wr1_data", 32'(bus1.FIFO_DATA), 32'(e.d));
            chk("wr1_ack", 32'(bus1.ACK), 32'(1 << e.r));
         end
      end
   end

   initial begin
      logic [N-1:0] gexp;
      bus.REQ        = '0;
      bus.FIFO_FULL  = 1'b0;
      bus1.REQ       = '0;
      bus1.FIFO_FULL = 1'b0;

      // Reset held with every requester asking.
      #2 RESET = 1'b0;
      bus.REQ = 4'b1111;
      repeat (2) @(negedge CLK);
      chk("rst_grant", 32'(bus.GRANT), 32'd0);
      chk("rst_we", 32'(bus.FIFO_WE), 32'd0);
      chk("rst_busy", 32'(bus.BUSY), 32'd0);
      chk("rst_ack", 32'(bus.ACK), 32'd0);
      chk("rst_data", 32'(bus.FIFO_DATA), 32'({2'd0, wc0[0]}));
      chk("rst1_grant", 32'(bus1.GRANT), 32'd0);

      // All four requesting: grants 0,1,2,3,0, four words each, one bubble between.
      @(posedge CLK); #1 RESET = 1'b1;
      for (int b = 0; b < 5; b++) push0(b % 4, 4);
      for (int c = 0; c < 25; c++) begin
         @(negedge CLK);
         gexp = (c % 5 == 0) ? 4'b0000 : 4'(1 << ((c / 5) % 4));
         chk("rr_grant", 32'(bus.GRANT), 32'(gexp));
         chk("rr_we", 32'(bus.FIFO_WE), 32'(c % 5 != 0));
         chk("rr_busy", 32'(bus.BUSY), 32'(c % 5 != 0));
      end
      @(posedge CLK); #1 bus.REQ = 4'b0000;
      @(negedge CLK);
      chk("rr_idle_grant", 32'(bus.GRANT), 32'd0);
      chk("rr_drain", 32'(q0.size()), 32'd0);

      // Requester 2 drops its request after two words.
      @(posedge CLK); #1 bus.REQ = 4'b0100;
      push0(2, 2);
      @(negedge CLK);
      chk("drop_idle", 32'(bus.GRANT), 32'd0);
      @(negedge CLK);
      chk("drop_grant", 32'(bus.GRANT), 32'b0100);
      chk("drop_w1", 32'(bus.FIFO_WE), 32'd1);
      @(negedge CLK);
      chk("drop_w2", 32'(bus.FIFO_WE), 32'd1);
      @(posedge CLK); #1 bus.REQ = 4'b0000;
      @(negedge CLK);
      chk("drop_rel_grant", 32'(bus.GRANT), 32'b0100);
      chk("drop_rel_we", 32'(bus.FIFO_WE), 32'd0);
      chk("drop_rel_ack", 32'(bus.ACK), 32'd0);
      @(negedge CLK);
      chk("drop_after_grant", 32'(bus.GRANT), 32'd0);
      chk("drop_after_busy", 32'(bus.BUSY), 32'd0);
      chk("drop_drain", 32'(q0.size()), 32'd0);

      // Requester 2 again: the count restarts, so a full burst of four is allowed.
      @(posedge CLK); #1 bus.REQ = 4'b0100;
      push0(2, 4);
      @(negedge CLK);
      chk("regrant_idle", 32'(bus.GRANT), 32'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         chk("regrant_grant", 32'(bus.GRANT), 32'b0100);
         chk("regrant_we", 32'(bus.FIFO_WE), 32'd1);
      end
      @(posedge CLK); #1 bus.REQ = 4'b0000;
      @(negedge CLK);
      chk("regrant_rel", 32'(bus.GRANT), 32'd0);
      chk("regrant_drain", 32'(q0.size()), 32'd0);

      // Requester 1: FULL for five cycles after the first word.
      @(posedge CLK); #1 bus.REQ = 4'b0010;
      push0(1, 4);
      @(negedge CLK);
      chk("full_idle", 32'(bus.GRANT), 32'd0);
      @(negedge CLK);
      chk("full_w1", 32'(bus.FIFO_WE), 32'd1);
      chk("full_grant", 32'(bus.GRANT), 32'b0010);
      @(posedge CLK); #1 bus.FIFO_FULL = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         chk("stall_we", 32'(bus.FIFO_WE), 32'd0);
         chk("stall_ack", 32'(bus.ACK), 32'd0);
         chk("stall_grant", 32'(bus.GRANT), 32'b0010);
      end
      @(posedge CLK); #1 bus.FIFO_FULL = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         chk("full_resume_we", 32'(bus.FIFO_WE), 32'd1);
         chk("full_resume_grant", 32'(bus.GRANT), 32'b0010);
      end
      @(posedge CLK); #1 bus.REQ = 4'b0000;
      @(negedge CLK);
      chk("full_rel", 32'(bus.GRANT), 32'd0);
      chk("full_drain", 32'(q0.size()), 32'd0);

      // BURST=1 instance: requesters 0 and 2 alternate, one word each.
      @(posedge CLK); #1 bus1.REQ = 4'b0101;
      push1(0); push1(2); push1(0); push1(2);
      for (int c = 0; c < 8; c++) begin
         @(negedge CLK);
         gexp = (c % 2 == 0) ? 4'b0000 : ((c % 4 == 1) ? 4'b0001 : 4'b0100);
         chk("b1_grant", 32'(bus1.GRANT), 32'(gexp));
         chk("b1_we", 32'(bus1.FIFO_WE), 32'(c % 2));
         chk("b1_no_odd_ack", 32'(bus1.ACK & 4'b1010), 32'd0);
      end
      @(posedge CLK); #1 bus1.REQ = 4'b0000;
      @(negedge CLK);
      chk("b1_rel", 32'(bus1.GRANT), 32'd0);
      chk("b1_drain", 32'(q1.size()), 32'd0);

      // Requester 3 is reset after two words; the pointer returns to 0.
      @(posedge CLK); #1 bus.REQ = 4'b1000;
      push0(3, 2);
      @(negedge CLK);
      chk("mid_idle", 32'(bus.GRANT), 32'd0);
      @(negedge CLK);
      chk("mid_grant", 32'(bus.GRANT), 32'b1000);
      @(negedge CLK);
      chk("mid_w2", 32'(bus.FIFO_WE), 32'd1);
      @(posedge CLK); #1;
      chk("mid_pre_we", 32'(bus.FIFO_WE), 32'd1);
      #1 RESET = 1'b0;
      #1;
      chk("mid_rst_grant", 32'(bus.GRANT), 32'd0);
      chk("mid_rst_we", 32'(bus.FIFO_WE), 32'd0);
      chk("mid_rst_ack", 32'(bus.ACK), 32'd0);
      chk("mid_rst_busy", 32'(bus.BUSY), 32'd0);
      @(posedge CLK); #1;
      bus.REQ = 4'b1001;
      RESET   = 1'b1;
      push0(0, 4);
      @(negedge CLK);
      chk("post_idle", 32'(bus.GRANT), 32'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         chk("post_grant", 32'(bus.GRANT), 32'b0001);
         chk("post_we", 32'(bus.FIFO_WE), 32'd1);
      end
      @(posedge CLK); #1 bus.REQ = 4'b0000;
      @(negedge CLK);
      chk("post_rel", 32'(bus.GRANT), 32'd0);
      chk("post_drain", 32'(q0.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the team's FIFO (WE, DATAIN, FULL) between N requesters.
- The winning requester keeps the grant for a burst of up to BURST accepted words, or until it drops its request. Grants then rotate.
- Sits in the write-clock domain, directly in front of the FIFO write port. It respects FULL as backpressure.

Parameters:
- N, 4, number of requesters (2..8).
- BITS, 8, data word width; must match the FIFO BITS.
- BURST, 4, maximum accepted words per grant (>=1).

Ports:
- CLK  input  1  single clock (FIFO write clock).
- RESET  input  1  asynchronous, active-low reset.
- REQ  input  N  per-requester word-valid; held high while data is pending.
- DATA  input  N*BITS  requester i word on DATA[i*BITS +: BITS].
- ACK  output  N  combinational; ACK[i]=1 means requester i's word is written this cycle.
- GRANT  output  N  registered one-hot grant, or all-zero.
- FIFO_WE  output  1  write enable to the FIFO.
- FIFO_DATA  output  BITS  write data to the FIFO.
- FIFO_FULL  input  1  FIFO full flag.
- BUSY  output  1  registered; 1 while in the LOCK state.

Behaviour:
- Reset (asynchronous, RESET=0) sets:
  - state=IDLE, GRANT=0, BUSY=0, priority pointer PTR=0, burst count CNT=0;
  - ACK=0 and FIFO_WE=0 (both derive from GRANT=0);
  - FIFO_DATA=DATA of requester 0 (mux follows the grant index, which is 0 at reset).
- Reset mid-burst aborts the burst immediately. No partial state survives.
- Let g be the index of the set bit in GRANT. Accept condition: acc = |GRANT & REQ[g] & ~FIFO_FULL.
- FIFO_WE = acc; ACK = GRANT & {N{acc}}; FIFO_DATA = DATA[g].
  - These are purely combinational from registers and inputs, so writes have zero added latency.
- State machine has two states, IDLE and LOCK.
- IDLE:
  - If REQ=0: stay in IDLE.
  - Else pick the first set REQ bit scanning from index PTR upward, modulo N.
  - Next cycle: GRANT=onehot(winner), state=LOCK, CNT=0, PTR=(winner+1) mod N, BUSY=1.
  - Arbitration costs exactly one cycle. No word is written in IDLE.
- LOCK:
  - On acc, CNT increments.
  - If REQ[g]=0 (request dropped): release; no write occurs that cycle.
  - If acc and CNT==BURST-1 (burst exhausted): release.
  - Release means next cycle state=IDLE, GRANT=0, CNT=0, BUSY=0.
  - If FIFO_FULL=1 and REQ[g]=1: hold the grant with CNT unchanged. There is no timeout, and FULL stall cycles do not consume burst quota.
- Bubble: exactly one idle cycle (IDLE state) between consecutive grants, including when the same requester re-wins. Sustained throughput is BURST/(BURST+1) words per cycle.
- Fairness: PTR always advances past the last winner. A continuously requesting requester waits at most (N-1) bursts.
- BURST=1: every grant lasts for one accepted word.
- Widths:
  - CNT is clog2(BURST+1) bits and never exceeds BURST-1.
  - PTR is clog2(N) bits (minimum 1) and wraps from N-1 to 0.
- REQ for a non-granted requester has no effect until the next IDLE cycle.
- A grant is never issued to a requester whose REQ was low in the IDLE cycle.
- FIFO_FULL is sampled combinationally only. The arbiter never relies on the FIFO ignoring WE when full; FIFO_WE is already 0 whenever FULL=1.

Decomposition:
- Shared FIFO package holds:
  - the BITS/SIZE defaults, so arbiter and FIFO widths agree;
  - the state encoding constants (IDLE=1'b0, LOCK=1'b1);
  - a clog2 constant function.
- One sub-module is natural: rr_pick, combinational.
  - Inputs: REQ and PTR. Outputs: winner index and any-valid.
  - Reusable by the read-side scheduler.
- Everything else stays in fifo_write_arbiter.

Test Plan:
- Reset with RESET=0 while REQ=4'b1111 -> GRANT=0, FIFO_WE=0, BUSY=0. After release, the first grant goes to requester 0 one cycle after the first IDLE cycle.
- N=4, BURST=4, REQ=4'b1111 held, FIFO_FULL=0 -> grants cycle 0,1,2,3,0. Each burst writes 4 words, then 1 bubble cycle; 20 words land in 25 cycles with FIFO_DATA matching the granted DATA slice.
- Requester 2 alone with REQ toggled low after 2 accepted words -> release after word 2, GRANT=0 next cycle. The next grant to requester 2 restarts CNT=0 and allows 4 words.
- FIFO_FULL=1 for 5 cycles in mid-burst after word 1 -> FIFO_WE=0 and ACK=0 during the stall, GRANT unchanged. After FULL drops, exactly 3 more words are written before release.
- BURST=1, REQ=4'b0101 -> grants alternate 0,2,0,2 with one word each and a bubble between. Requesters 1 and 3 are never acked.
- Assert RESET=0 mid-burst (CNT=2, requester 3) -> GRANT=0 immediately (asynchronous). After reset the pointer is back at 0 and the next grant goes to requester 0 if it is requesting.
